// File: rtl/dotprod_stream_if.sv
// Streaming dot-product handshake bundle: element-pair input stream and result output.
// The slave modport is the dotprod_stream side; the master modport is the producer/consumer side.
interface dotprod_stream_if #(
  parameter int DW = 16,
  parameter int OW = 19
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/dotprod_stream.sv
// Streaming dot product of N element pairs with a registered, held result.
// Optional macro DOTPROD_STREAM_SIGNED_EN selects two's complement operands (default unsigned).
//
// state | meaning
// ACC   | accepting pairs, accumulating products
// DONE  | result valid on out, waiting for out_ready
module dotprod_stream #(
  parameter int N  = 8,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            nreset,
  dotprod_stream_if.slave bus
);
  localparam int OW = DW + $clog2(N);
  localparam int CW = $clog2(N) + 1;
  localparam int PW = (2 * DW > OW) ? 2 * DW : OW;

  typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] acc;
  logic [OW-1:0] out_r;
  logic [CW-1:0] cnt;
  logic [PW-1:0] a_x, b_x, prod_w;
  logic [OW-1:0] sum;
  logic          xfer;
  logic          last;

`ifdef DOTPROD_STREAM_SIGNED_EN
  assign a_x = PW'($signed(bus.in_a));
  assign b_x = PW'($signed(bus.in_b));
`else
  assign a_x = PW'(bus.in_a);
  assign b_x = PW'(bus.in_b);
`endif

  // Low PW bits of the product are identical for signed and unsigned once extended.
  assign prod_w = a_x * b_x;
  assign sum    = acc + prod_w[OW-1:0];
  assign xfer   = (state == ACC) && bus.in_valid;
  assign last   = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ACC;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:  if (xfer && last) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      ACC:     bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc   <= '0;
      cnt   <= '0;
      out_r <= '0;
    end else if (xfer) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
      if (last) out_r <= sum;
    end else if ((state == DONE) && bus.out_ready) begin
      acc <= '0;
      cnt <= '0;
    end
  end

  assign bus.out = out_r;
endmodule

// File: tb/tb_dotprod_stream.sv
// Directed self-checking bench for dotprod_stream (N=8, DW=16, OW=19).
module tb_dotprod_stream;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int OW = 19;

  logic clk;
  logic nreset;
  int   vectors;
  int   miscompares;

  dotprod_stream_if #(.DW(DW), .OW(OW)) bus ();

  dotprod_stream #(.N(N), .DW(DW)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the following rising edge performs the transfer.
  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = 16'hDEAD;
    bus.in_b     = 16'hBEEF;
  endtask

  task automatic test_reset();
    nreset        = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_a      = 16'd5;
    bus.in_b      = 16'd5;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.out !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_out: got %0d want 0", bus.out);
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    nreset       = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic_sum();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= N; i++) begin
      if (i == N) begin
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL basic_early_valid: got %b want 0", bus.out_valid);
        end
        bus.in_valid = 1'b1;
        bus.in_a     = 16'(i);
        bus.in_b     = 16'd1;
      end else begin
        send_pair(16'(i), 16'd1);
      end
    end
    idle_cycle();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out !== 19'd36) begin
      miscompares++;
      $display("FAIL basic_result: got valid=%b out=%0d want valid=1 out=36", bus.out_valid, bus.out);
    end
    idle_cycle();
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_return: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    vectors++;
    if (bus.out !== 19'd36) begin
      miscompares++;
      $display("FAIL basic_out_retained: got %0d want 36", bus.out);
    end
  endtask

  task automatic test_wrap();
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) send_pair(16'hFFFF, 16'hFFFF);
    idle_cycle();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out !== 19'h00008) begin
      miscompares++;
      $display("FAIL wrap_result: got valid=%b out=%h want valid=1 out=00008", bus.out_valid, bus.out);
    end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      send_pair(16'd2, 16'd3);
      idle_cycle();
    end
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out !== 19'd48 || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got valid=%b out=%0d in_ready=%b want 1 48 0",
                 k, bus.out_valid, bus.out, bus.in_ready);
      end
      send_pair(16'd100, 16'd100);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    vectors++;
    if (bus.out !== 19'd48) begin
      miscompares++;
      $display("FAIL bp_after_pulses: got %0d want 48", bus.out);
    end
    idle_cycle();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    for (int i = 1; i <= N; i++) send_pair(16'(i), 16'd2);
    idle_cycle();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out !== 19'd72) begin
      miscompares++;
      $display("FAIL bp_next_result: got valid=%b out=%0d want 1 72", bus.out_valid, bus.out);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_pair(16'd5, 16'd5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    nreset       = 1'b0;
    #1;
    vectors++;
    if (bus.out !== 19'd0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_async: got out=%0d valid=%b want 0 0", bus.out, bus.out_valid);
    end
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < N; i++) send_pair(16'd1, 16'd1);
    idle_cycle();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out !== 19'd8) begin
      miscompares++;
      $display("FAIL mid_reset_result: got valid=%b out=%0d want 1 8", bus.out_valid, bus.out);
    end
    idle_cycle();
  endtask

  task automatic test_signedness();
    logic [OW-1:0] exp_one;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) send_pair(16'hFFFF, 16'd2);
    idle_cycle();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out !== 19'h7FFF0) begin
      miscompares++;
      $display("FAIL neg_times_two: got valid=%b out=%h want 1 7fff0", bus.out_valid, bus.out);
    end
    idle_cycle();
`ifdef DOTPROD_STREAM_SIGNED_EN
    exp_one = 19'h7FFFF;
`else
    exp_one = 19'h0FFFF;
`endif
    send_pair(16'hFFFF, 16'd1);
    for (int i = 1; i < N; i++) send_pair(16'd0, 16'd0);
    idle_cycle();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out !== exp_one) begin
      miscompares++;
      $display("FAIL sign_extend: got valid=%b out=%h want 1 %h", bus.out_valid, bus.out, exp_one);
    end
    idle_cycle();
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    nreset        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic_sum();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_signedness();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dotprod_stream.md
DOTPROD_STREAM -- requirements
Module: dotprod_stream

Interface
REQ-001 SHALL have parameter N, default 8: number of element pairs per dot product (N >= 2).
REQ-002 SHALL have parameter DW, default 16: element width in bits.
REQ-003 SHALL define OW = DW + $clog2(N) as the result width.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port nreset  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1: element pair present.
REQ-007 SHALL have port in_ready  output  1: block accepts a pair this cycle.
REQ-008 SHALL have port in_a  input  DW: vector a element.
REQ-009 SHALL have port in_b  input  DW: vector b element.
REQ-010 SHALL have port out_valid  output  1: result available.
REQ-011 SHALL have port out_ready  input  1: downstream consumes the result.
REQ-012 SHALL have port out  output  OW: registered sum of products.

Function
REQ-013 SHALL accept a pair only on a cycle where in_valid and in_ready are both 1 (transfer); other cycles leave state unchanged.
REQ-014 SHALL implement two states: ACC (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-015 SHALL, in ACC, add in_a*in_b to an OW-bit accumulator on each transfer and increment a pair counter (width $clog2(N)+1).
REQ-016 SHALL truncate all arithmetic modulo 2^OW; overflow SHALL wrap silently with no flag.
REQ-017 SHALL, on the Nth transfer, load out with the accumulator plus the Nth product and enter DONE; out_valid SHALL be 1 in the following cycle (latency 1 cycle after the last transfer).
REQ-018 SHALL hold out and out_valid stable in DONE until out_ready=1.
REQ-019 SHALL, in DONE with out_ready=1, clear the accumulator and counter, deassert out_valid and return to ACC the next cycle.
REQ-020 SHALL ignore in_valid, in_a and in_b while in DONE.
REQ-021 SHALL tolerate arbitrary in_valid bubbles; the result depends only on the transferred pairs.
REQ-022 SHALL sustain at best one dot product every N+1 cycles (N transfers plus one DONE cycle with out_ready=1).
REQ-023 SHALL retain out at its last value after leaving DONE until the next result is loaded.

Reset
REQ-024 SHALL, while nreset=0, asynchronously force state ACC, accumulator 0, counter 0, out 0 and out_valid 0.
REQ-025 SHALL drive in_ready=1 from the first rising clk edge after nreset deasserts.
REQ-026 SHALL, on reset mid-accumulation, discard all partial sums; the next N transfers form a fresh result.

Configuration
REQ-027 SHALL support the macro DOTPROD_STREAM_SIGNED_EN.
REQ-028 SHALL, with DOTPROD_STREAM_SIGNED_EN defined, treat in_a and in_b as two's complement and sign-extend each product to OW bits before accumulation; out is two's complement.
REQ-029 SHALL, without DOTPROD_STREAM_SIGNED_EN, treat all operands as unsigned and zero-extend products; this is the default build.

Verification (N=8, DW=16, OW=19)
REQ-030 SHALL cover reset: hold nreset=0 with in_valid=1 -> out=0, out_valid=0; first edge after release -> in_ready=1.
REQ-031 SHALL cover basic sum: in_a=1..8, in_b=1 on consecutive cycles, out_ready=1 -> out=36, out_valid=1 exactly one cycle after the 8th transfer, in_ready=1 one cycle later.
REQ-032 SHALL cover wrap (unsigned build): 8 pairs of 0xFFFF*0xFFFF -> out=0x00008.
REQ-033 SHALL cover backpressure and bubbles: pairs 2,3 x8 with in_valid low every other cycle, out_ready=0 for 5 cycles after the result -> out=48 held stable, in_ready=0, extra in_valid pulses ignored; the next dot product is unaffected.
REQ-034 SHALL cover reset mid-operation: assert nreset=0 after 4 transfers of 5*5, then send 8 pairs of 1*1 -> out=8.
REQ-035 SHALL cover the signed build: 8 pairs in_a=0xFFFF (-1), in_b=2 -> out=0x7FFF0 (-16).
